// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receive path.
// States, command ASCII codes and bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        KIND_QUARTER,
        KIND_DIME,
        KIND_CONFIRM,
        KIND_OTHER
    } cmd_kind_t;

    localparam logic [7:0] CMD_Q    = 8'h71;
    localparam logic [7:0] CMD_Q_UC = 8'h51;
    localparam logic [7:0] CMD_D    = 8'h64;
    localparam logic [7:0] CMD_D_UC = 8'h44;
    localparam logic [7:0] CMD_C    = 8'h63;
    localparam logic [7:0] CMD_C_UC = 8'h43;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Serial line in, decoded command pulses and receive status out.
// master drives the line; slave is the decoder.
interface uart_cmd_decoder_if;

    logic       UART_RX;
    logic       quarter_uart;
    logic       dime_uart;
    logic       confirm_uart;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_err;

    modport master (
        output UART_RX,
        input  quarter_uart,
        input  dime_uart,
        input  confirm_uart,
        input  rx_byte,
        input  rx_valid,
        input  frame_err,
        input  cmd_err
    );

    modport slave (
        input  UART_RX,
        output quarter_uart,
        output dime_uart,
        output confirm_uart,
        output rx_byte,
        output rx_valid,
        output frame_err,
        output cmd_err
    );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, framing FSM and shift register.
// stop_ok flags the cycle the stop bit samples high.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] shift,
    output logic       stop_ok
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic          sync1;
    logic          rx_s;
    logic          baud_tick;

    assign baud_tick = (baud_cnt == LAST);
    assign stop_ok   = (state == STOP) && baud_tick && rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == MID) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        shift    <= {rx_s, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // a held-low line must go high before a new start is seen
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Receives 8N1 bytes and turns q/d/c (any case) into one-cycle pulses.
// Pulses line up with rx_valid; unknown bytes raise cmd_err.
module uart_cmd_decoder
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input logic          clk,
    input logic          reset,
    uart_cmd_decoder_if.slave bus
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] shift;
    logic       stop_ok;
    cmd_kind_t  kind;
    logic       quarter;
    logic       dime;
    logic       confirm;
    logic       bad_cmd;

    uart_rx_core #(
        .CLKS_PER_BIT(CPB)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .rx       (bus.UART_RX),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .shift    (shift),
        .stop_ok  (stop_ok)
    );

    always_comb begin
        kind = KIND_OTHER;
        unique case (1'b1)
            (shift == CMD_Q) || (shift == CMD_Q_UC): kind = KIND_QUARTER;
            (shift == CMD_D) || (shift == CMD_D_UC): kind = KIND_DIME;
            (shift == CMD_C) || (shift == CMD_C_UC): kind = KIND_CONFIRM;
            default:                                 kind = KIND_OTHER;
        endcase
    end

    // registered on the stop-sample edge so pulses coincide with rx_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quarter <= 1'b0;
            dime    <= 1'b0;
            confirm <= 1'b0;
            bad_cmd <= 1'b0;
        end else begin
            quarter <= stop_ok && (kind == KIND_QUARTER);
            dime    <= stop_ok && (kind == KIND_DIME);
            confirm <= stop_ok && (kind == KIND_CONFIRM);
            bad_cmd <= stop_ok && (kind == KIND_OTHER);
        end
    end

    assign bus.quarter_uart = quarter;
    assign bus.dime_uart    = dime;
    assign bus.confirm_uart = confirm;
    assign bus.cmd_err      = bad_cmd;
    assign bus.rx_byte      = rx_byte;
    assign bus.rx_valid     = rx_valid;
    assign bus.frame_err    = frame_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder at 10 clocks per bit.
// Event counts per frame are compared with a case-insensitive ASCII model.
module tb_uart_cmd_decoder;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   cnt[6];
    int   last_cyc[6];
    int   bad = 0;
    string names[6] = '{"quarter", "dime", "confirm", "cmd_err",
                        "rx_valid", "frame_err"};
    logic [7:0] cmds[6] = '{8'h71, 8'h51, 8'h64, 8'h44, 8'h63, 8'h43};
    logic [7:0] exp_byte = 8'h00;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int k = 0; k < 6; k++) begin
            cnt[k] = 0;
            last_cyc[k] = -1;
        end
    end

    // event tally plus exclusivity watch on every cycle
    always @(negedge clk) begin
        logic [5:0] ev;
        int n;
        ev = {bus.frame_err, bus.rx_valid, bus.cmd_err,
              bus.confirm_uart, bus.dime_uart, bus.quarter_uart};
        n = int'(ev[0]) + int'(ev[1]) + int'(ev[2]) + int'(ev[3]);
        for (int k = 0; k < 6; k++)
            if (ev[k] === 1'b1) begin
                cnt[k] = cnt[k] + 1;
                last_cyc[k] = cyc;
            end
        if (bus.rx_valid === 1'b1 && n != 1) bad = bad + 1;
        if (bus.rx_valid !== 1'b1 && n != 0) bad = bad + 1;
        if (bus.frame_err === 1'b1 && (bus.rx_valid === 1'b1 || n != 0))
            bad = bad + 1;
    end

    // reference: which events a frame should raise (bit order as cnt[])
    function automatic logic [5:0] model(input logic [7:0] b, input bit ok);
        logic [7:0] lc;
        logic [5:0] m;
        m = '0;
        if (!ok) begin
            m[5] = 1'b1;
            return m;
        end
        m[4] = 1'b1;
        lc = b | 8'h20;
        if (lc == "q") m[0] = 1'b1;
        else if (lc == "d") m[1] = 1'b1;
        else if (lc == "c") m[2] = 1'b1;
        else m[3] = 1'b1;
        return m;
    endfunction

    task automatic hold_line(input logic v, input int n);
        bus.UART_RX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok,
                              input int low_hold);
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
        if (ok) hold_line(1'b1, CPB);
        else hold_line(1'b0, low_hold);
        bus.UART_RX = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        repeat (3) @(negedge clk);
        obs = {bus.frame_err, bus.rx_valid, bus.cmd_err,
               bus.confirm_uart, bus.dime_uart, bus.quarter_uart};
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got %b want 000000", obs);
        end
        vectors++;
        if (bus.rx_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rx_byte got %h want 00", bus.rx_byte);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        hold_line(1'b1, 5);
    endtask

    task automatic test_single(input logic [7:0] b);
        int base[6];
        logic [5:0] m;
        base = cnt;
        m = model(b, 1'b1);
        send_frame(b, 1'b1, 0);
        hold_line(1'b1, 5);
        exp_byte = b;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (cnt[k] - base[k] !== int'(m[k])) begin
                miscompares++;
                $display("FAIL single_%h_%s got %0d want %0d", b, names[k],
                         cnt[k] - base[k], m[k]);
            end
        end
        vectors++;
        if (bus.rx_byte !== exp_byte) begin
            miscompares++;
            $display("FAIL single_%h_byte got %h want %h", b, bus.rx_byte,
                     exp_byte);
        end
    endtask

    task automatic test_back_to_back();
        int base[6];
        base = cnt;
        send_frame(8'h44, 1'b1, 0);
        send_frame(8'h63, 1'b1, 0);
        hold_line(1'b1, 5);
        exp_byte = 8'h63;
        vectors++;
        if (cnt[1] - base[1] !== 1 || cnt[2] - base[2] !== 1 ||
            cnt[4] - base[4] !== 2) begin
            miscompares++;
            $display("FAIL b2b_counts got d=%0d c=%0d v=%0d want 1 1 2",
                     cnt[1] - base[1], cnt[2] - base[2], cnt[4] - base[4]);
        end
        vectors++;
        if (last_cyc[2] - last_cyc[1] !== 10 * CPB) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want %0d",
                     last_cyc[2] - last_cyc[1], 10 * CPB);
        end
        vectors++;
        if (bus.rx_byte !== exp_byte) begin
            miscompares++;
            $display("FAIL b2b_byte got %h want %h", bus.rx_byte, exp_byte);
        end
    endtask

    task automatic test_frame_err();
        int base[6];
        base = cnt;
        send_frame(8'h71, 1'b0, 30);
        hold_line(1'b1, 5);
        vectors++;
        if (cnt[5] - base[5] !== 1 || cnt[4] - base[4] !== 0) begin
            miscompares++;
            $display("FAIL ferr_counts got f=%0d v=%0d want 1 0",
                     cnt[5] - base[5], cnt[4] - base[4]);
        end
        vectors++;
        if (bus.rx_byte !== exp_byte) begin
            miscompares++;
            $display("FAIL ferr_byte got %h want %h", bus.rx_byte, exp_byte);
        end
        test_single(8'h71);
    endtask

    task automatic test_glitch();
        int base[6];
        base = cnt;
        hold_line(1'b0, 3);
        hold_line(1'b1, 30);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (cnt[k] !== base[k]) begin
                miscompares++;
                $display("FAIL glitch_%s got %0d want 0", names[k],
                         cnt[k] - base[k]);
            end
        end
        test_single(8'h64);
    endtask

    task automatic test_reset_mid_frame();
        int base[6];
        logic [7:0] b;
        logic [5:0] obs;
        b = 8'h63;
        base = cnt;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold_line(b[i], CPB);
        hold_line(b[4], CPB / 2);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {bus.frame_err, bus.rx_valid, bus.cmd_err,
                   bus.confirm_uart, bus.dime_uart, bus.quarter_uart};
            vectors++;
            if (obs !== 6'b0 || bus.rx_byte !== 8'h00) begin
                miscompares++;
                $display("FAIL midreset_outputs got %b/%h want 000000/00",
                         obs, bus.rx_byte);
            end
        end
        bus.UART_RX = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        hold_line(1'b1, 20);
        exp_byte = 8'h00;
        send_frame(8'h71, 1'b1, 0);
        hold_line(1'b1, 5);
        exp_byte = 8'h71;
        vectors++;
        if (cnt[2] !== base[2] || cnt[0] - base[0] !== 1 ||
            cnt[4] - base[4] !== 1) begin
            miscompares++;
            $display("FAIL midreset_counts got c=%0d q=%0d v=%0d want 0 1 1",
                     cnt[2] - base[2], cnt[0] - base[0], cnt[4] - base[4]);
        end
        vectors++;
        if (bus.rx_byte !== exp_byte) begin
            miscompares++;
            $display("FAIL midreset_byte got %h want %h", bus.rx_byte,
                     exp_byte);
        end
    endtask

    task automatic test_random(input int n);
        int base[6];
        logic [7:0] b;
        bit ok;
        logic [5:0] m;
        for (int f = 0; f < n; f++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = cmds[$urandom_range(0, 5)];
            ok = ($urandom_range(0, 4) != 0);
            m = model(b, ok);
            base = cnt;
            send_frame(b, ok, int'($urandom_range(10, 30)));
            hold_line(1'b1, int'($urandom_range(4, 15)));
            if (ok) exp_byte = b;
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (cnt[k] - base[k] !== int'(m[k])) begin
                    miscompares++;
                    $display("FAIL rand%0d_%h_%s got %0d want %0d", f, b,
                             names[k], cnt[k] - base[k], m[k]);
                end
            end
            vectors++;
            if (bus.rx_byte !== exp_byte) begin
                miscompares++;
                $display("FAIL rand%0d_byte got %h want %h", f, bus.rx_byte,
                         exp_byte);
            end
        end
    endtask

    task automatic test_exclusive();
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL exclusive_pulses got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.UART_RX = 1'b1;
        test_reset();
        test_single(8'h71);
        test_back_to_back();
        test_single(8'h7A);
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_random(24);
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Upstream stage of the UART driver: receives 8N1 serial bytes on UART_RX and decodes ASCII commands into single-cycle pulses (quarter_uart, dime_uart, confirm_uart).
- These pulses are OR-able with the debounced button pulses feeding the vending FSM.
- Also exposes the raw received byte and error strobes for the TX/echo path and for debug.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division. Must be >= 4.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- UART_RX  input  1  serial line, idle high, asynchronous to clk.
- quarter_uart  output  1  one-cycle pulse on 'q' or 'Q'.
- dime_uart  output  1  one-cycle pulse on 'd' or 'D'.
- confirm_uart  output  1  one-cycle pulse on 'c' or 'C'.
- rx_byte  output  8  last correctly framed byte; held until the next valid byte.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- cmd_err  output  1  one-cycle pulse when a valid byte is not a recognised command.

Behaviour:
- Clocking and reset:
  - One clock domain: clk. Reset is asynchronous and active-high.
  - On reset: all pulses = 0, rx_byte = 8'h00, state = IDLE, bit counter = 0, baud counter = 0, both synchroniser flops = 1.
- Input synchroniser: UART_RX passes through a 2-flop synchroniser, rx_s. All sampling uses rx_s.
- Receiver FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s == 0, clear baud counter and go to START.
  - START: at baud count CLKS_PER_BIT/2 - 1 (mid start bit), if rx_s == 1 it is a false start: return to IDLE, no outputs. If rx_s == 0, reset the counter and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: latch rx_byte, pulse rx_valid, go to IDLE.
    - If 0: pulse frame_err, discard the byte (rx_byte unchanged), go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. This prevents a held-low line from re-triggering.
- Command decode, combinational on the shift register, registered into the pulses:
  - Outputs assert in the same cycle as rx_valid: exactly one clk high, one cycle after the stop-bit sample edge.
  - 8'h71/8'h51 -> quarter_uart. 8'h64/8'h44 -> dime_uart. 8'h63/8'h43 -> confirm_uart. Any other valid byte -> cmd_err.
  - At most one of quarter_uart, dime_uart, confirm_uart, cmd_err is high in any cycle. None of them fire with frame_err.
- Back-to-back frames: a start bit immediately after the stop bit (no idle gap) must be received. IDLE detects a low rx_s on the cycle after leaving STOP.
- Reset mid-frame: the partial byte is discarded, no pulses are issued, and the block resumes in IDLE. If reset releases while the line is low, the block goes IDLE -> START, then false-start or frames normally.
- Latency: UART_RX transition to internal sampling is 2 clks (synchroniser). Stop-bit midpoint to pulse is 1 clk.
- Counters:
  - Baud counter width = $clog2(CLKS_PER_BIT).
  - Bit counter is 3 bits and wraps 7 -> 0 on exit from DATA.

Decomposition:
- Package uart_pkg:
  - state encoding localparams: IDLE, START, DATA, STOP, BREAK.
  - ASCII command constants: CMD_Q, CMD_D, CMD_C and their upper-case forms.
  - CLKS_PER_BIT calculation function.
- Sub-module uart_rx_core, containing:
  - synchroniser;
  - receiver FSM;
  - shift register;
  - outputs: byte, valid, frame_err.
- uart_cmd_decoder instantiates uart_rx_core and adds the decode/pulse register.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clks/bit):
- Send 8'h71 ('q'), 8N1 -> exactly one quarter_uart pulse, rx_valid = 1 in the same cycle, rx_byte = 8'h71; all other pulses 0.
- Send 'D' then 'c' back-to-back with no idle gap -> dime_uart pulse, then confirm_uart pulse 100 clks later; rx_byte ends at 8'h63.
- Send 8'h7A ('z') -> cmd_err pulse only; rx_byte = 8'h7A; no command pulse.
- Send 8'h71 with stop bit = 0, holding the line low 30 clks -> frame_err pulse; rx_byte unchanged from before; no re-trigger until the line goes high. A following 'q' decodes correctly.
- Drive a 3-clk low glitch on an idle line -> no pulses; state returns to IDLE; the next 'd' decodes.
- Assert reset during bit 4 of 'c', release, then send 'q' -> no confirm_uart pulse; one quarter_uart pulse; all outputs 0 while reset is high.
